// File: rtl/video_mono_mode_ctrl_pkg.sv
// video_mono_pkg: shared types for the monochrome-mode sequencer.
//   mono_mode_t : the eight monitor-emulation modes (gfx_mode encoding)
//   state_t     : sequencer states
//   cnt_width() : width of the blank-frame counter for a given frame count
package video_mono_pkg;

  typedef enum logic [2:0] {
    COLOR   = 3'd0,
    GREEN   = 3'd1,
    AMBER   = 3'd2,
    BW      = 3'd3,
    RED     = 3'd4,
    BLUE    = 3'd5,
    FUCHSIA = 3'd6,
    PURPLE  = 3'd7
  } mono_mode_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_VBL = 3'd1,
    BLANK    = 3'd2,
    UNBLANK  = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Counter must hold values 1..frames; never narrower than one bit.
  function automatic int cnt_width(input int frames);
    return (frames < 1) ? 1 : $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/video_mono_mode_ctrl_if.sv
// video_mono_mode_ctrl_if: signal bundle between the OSD/CRTC side and the
// mode sequencer, all in the clk_vid domain.
//   vblank      : vertical blank from the CRTC
//   mode_req    : requested mode (level)
//   mode_next   : hotkey pulse, present only with VIDEO_MONO_HOTKEY_EN
//   gfx_mode    : mode driven to the converter
//   video_blank : force RGB to black downstream
//   busy        : sequencer not idle
//   switch_done : one-cycle pulse at the end of a sequence
// Modports: master = request/timing source, slave = sequencer.
interface video_mono_mode_ctrl_if;
  import video_mono_pkg::*;

  logic       vblank;
  logic [2:0] mode_req;
`ifdef VIDEO_MONO_HOTKEY_EN
  logic       mode_next;
`endif
  logic [2:0] gfx_mode;
  logic       video_blank;
  logic       busy;
  logic       switch_done;

  modport master (
    output vblank,
    output mode_req,
`ifdef VIDEO_MONO_HOTKEY_EN
    output mode_next,
`endif
    input  gfx_mode,
    input  video_blank,
    input  busy,
    input  switch_done
  );

  modport slave (
    input  vblank,
    input  mode_req,
`ifdef VIDEO_MONO_HOTKEY_EN
    input  mode_next,
`endif
    output gfx_mode,
    output video_blank,
    output busy,
    output switch_done
  );

endinterface

// File: rtl/video_mono_mode_ctrl.sv
// video_mono_mode_ctrl: applies monitor-emulation mode changes only at frame
// boundaries, holding the output blanked for BLANK_FRAMES vblank rises so no
// torn or mixed-palette frame reaches the scaler.
// Ports:
//   clk_vid : video clock
//   reset   : asynchronous, active-high reset
//   vid     : video_mono_mode_ctrl_if.slave (vblank, mode_req, [mode_next],
//             gfx_mode, video_blank, busy, switch_done)
// Parameters: BLANK_FRAMES (0 = switch without blanking), RESET_MODE.
// Optional feature macro: VIDEO_MONO_HOTKEY_EN adds the mode_next hotkey,
// which steps an internal request register through the modes.
module video_mono_mode_ctrl
  import video_mono_pkg::*;
#(
  parameter int         BLANK_FRAMES = 2,
  parameter logic [2:0] RESET_MODE   = 3'd0
) (
  input  logic           clk_vid,
  input  logic           reset,
  video_mono_mode_ctrl_if.slave vid
);

  localparam int                CNT_W   = cnt_width(BLANK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLANK_FRAMES);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_WAIT    = WAIT_VBL;
  localparam logic [2:0] S_BLANK   = BLANK;
  localparam logic [2:0] S_UNBLANK = UNBLANK;
  localparam logic [2:0] S_DONE    = DONE;

  logic [2:0]       state_q, state_d;
  logic [2:0]       gfx_q, gfx_d;
  logic             blank_q, blank_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vblank_q;
  logic             vbl_rise;
  logic [2:0]       req;

  // vblank edge detector
  assign vbl_rise = vid.vblank & ~vblank_q;

`ifdef VIDEO_MONO_HOTKEY_EN
  logic [2:0] hk_mode_q, hk_mode_d;
  logic [2:0] mode_req_q;

  // A change of mode_req has priority over a coincident hotkey pulse.
  always_comb begin
    hk_mode_d = hk_mode_q;
    if (vid.mode_req != mode_req_q) begin
      hk_mode_d = vid.mode_req;
    end else if (vid.mode_next) begin
      hk_mode_d = hk_mode_q + 3'd1;
    end
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      hk_mode_q  <= RESET_MODE;
      mode_req_q <= RESET_MODE;
    end else begin
      hk_mode_q  <= hk_mode_d;
      mode_req_q <= vid.mode_req;
    end
  end

  assign req = hk_mode_q;
`else
  assign req = vid.mode_req;
`endif

  // Next-state logic. The mode applied at the switch point is the request
  // present at that instant; any later difference is picked up in DONE.
  always_comb begin
    state_d = state_q;
    gfx_d   = gfx_q;
    blank_d = blank_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req != gfx_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (req == gfx_q) begin
          state_d = S_IDLE;
        end else if (vbl_rise) begin
          if (BLANK_FRAMES == 0) begin
            gfx_d   = req;
            state_d = S_DONE;
          end else begin
            blank_d = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = S_BLANK;
          end
        end
      end
      S_BLANK: begin
        if (vbl_rise) begin
          if (cnt_q == CNT_MAX) begin
            gfx_d   = req;
            state_d = S_UNBLANK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_UNBLANK: begin
        // Keep blanking one more frame so the converter pipeline flushes.
        if (vbl_rise) begin
          blank_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = (req != gfx_q) ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gfx_q    <= RESET_MODE;
      blank_q  <= 1'b0;
      cnt_q    <= '0;
      vblank_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gfx_q    <= gfx_d;
      blank_q  <= blank_d;
      cnt_q    <= cnt_d;
      vblank_q <= vid.vblank;
    end
  end

  assign vid.gfx_mode    = gfx_q;
  assign vid.video_blank = blank_q;
  assign vid.busy        = (state_q != S_IDLE);
  assign vid.switch_done = (state_q == S_DONE);

endmodule

// File: tb/tb_video_mono_mode_ctrl.sv
// Testbench for video_mono_mode_ctrl: one instance with BLANK_FRAMES=2 (A)
// and one with BLANK_FRAMES=0 (B). A vector table drives vblank/mode_req on
// the falling edge and checks {gfx_mode, video_blank, busy, switch_done}
// one time unit after the following rising edge; hand-written sequences
// cover asynchronous reset mid-sequence and vblank held high across reset.
module tb_video_mono_mode_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  video_mono_mode_ctrl_if ifa ();
  video_mono_mode_ctrl_if ifb ();

  video_mono_mode_ctrl #(.BLANK_FRAMES(2), .RESET_MODE(3'd0)) dut_a (
    .clk_vid (clk),
    .reset   (rst),
    .vid     (ifa)
  );

  video_mono_mode_ctrl #(.BLANK_FRAMES(0), .RESET_MODE(3'd0)) dut_b (
    .clk_vid (clk),
    .reset   (rst),
    .vid     (ifb)
  );

  typedef struct {
    logic       sel;   // 0 = instance A, 1 = instance B
    logic       vb;
    logic [2:0] req;
    logic [2:0] g;
    logic       b;
    logic       bs;
    logic       d;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void add(input logic sel, input logic vb, input logic [2:0] req,
                              input logic [2:0] g, input logic b, input logic bs,
                              input logic d);
    vec_t v;
    v.sel = sel; v.vb = vb; v.req = req;
    v.g = g; v.b = b; v.bs = bs; v.d = d;
    vecs.push_back(v);
  endfunction

  function automatic logic [5:0] outs_a();
    return {ifa.gfx_mode, ifa.video_blank, ifa.busy, ifa.switch_done};
  endfunction

  function automatic logic [5:0] outs_b();
    return {ifb.gfx_mode, ifb.video_blank, ifb.busy, ifb.switch_done};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got gfx=%0d blank=%0b busy=%0b done=%0b, expected gfx=%0d blank=%0b busy=%0b done=%0b",
               name, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    logic [5:0] exp;
    logic [5:0] act;

    ifa.vblank = 1'b0; ifa.mode_req = 3'd0;
    ifb.vblank = 1'b0; ifb.mode_req = 3'd0;
`ifdef VIDEO_MONO_HOTKEY_EN
    ifa.mode_next = 1'b0;
    ifb.mode_next = 1'b0;
`endif

    // A: idle with no request over three frames
    add(0, 0, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // A: 0 -> 1, blank at rise 1, switch at rise 3, unblank at rise 4
    add(0, 0, 1, 0, 0, 1, 0); add(0, 0, 1, 0, 0, 1, 0); add(0, 1, 1, 0, 1, 1, 0);
    add(0, 1, 1, 0, 1, 1, 0); add(0, 0, 1, 0, 1, 1, 0); add(0, 1, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0); add(0, 1, 1, 1, 1, 1, 0); add(0, 0, 1, 1, 1, 1, 0);
    add(0, 1, 1, 1, 0, 1, 1); add(0, 1, 1, 1, 0, 0, 0); add(0, 0, 1, 1, 0, 0, 0);
    // A: request withdrawn before any vblank rise
    add(0, 0, 2, 1, 0, 1, 0); add(0, 0, 1, 1, 0, 0, 0); add(0, 1, 1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0);
    // A: 1 -> 3, retargeted to 5 while blanked; 3 never appears
    add(0, 0, 3, 1, 0, 1, 0); add(0, 1, 3, 1, 1, 1, 0); add(0, 0, 5, 1, 1, 1, 0);
    add(0, 1, 5, 1, 1, 1, 0); add(0, 0, 5, 1, 1, 1, 0); add(0, 1, 5, 5, 1, 1, 0);
    add(0, 0, 5, 5, 1, 1, 0); add(0, 1, 5, 5, 0, 1, 1); add(0, 0, 5, 5, 0, 0, 0);
    // A: 5 -> 2, request moves to 4 after the switch; DONE re-runs the sequence
    add(0, 0, 2, 5, 0, 1, 0); add(0, 1, 2, 5, 1, 1, 0); add(0, 0, 2, 5, 1, 1, 0);
    add(0, 1, 2, 5, 1, 1, 0); add(0, 0, 2, 5, 1, 1, 0); add(0, 1, 2, 2, 1, 1, 0);
    add(0, 0, 4, 2, 1, 1, 0); add(0, 1, 4, 2, 0, 1, 1); add(0, 0, 4, 2, 0, 1, 0);
    add(0, 1, 4, 2, 1, 1, 0);
    // B: no blanking, switch one cycle after the first vblank rise
    add(1, 0, 3, 0, 0, 1, 0); add(1, 1, 3, 3, 0, 1, 1); add(1, 0, 3, 3, 0, 0, 0);
    add(1, 0, 7, 3, 0, 1, 0); add(1, 0, 7, 3, 0, 1, 0); add(1, 1, 7, 7, 0, 1, 1);
    add(1, 1, 7, 7, 0, 0, 0);

    // Reset state while reset is held
    #3;
    check("reset_a", outs_a(), 6'b000_0_0_0);
    check("reset_b", outs_b(), 6'b000_0_0_0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].sel == 1'b0) begin
        ifa.vblank = vecs[i].vb; ifa.mode_req = vecs[i].req;
      end else begin
        ifb.vblank = vecs[i].vb; ifb.mode_req = vecs[i].req;
      end
      @(posedge clk);
      #1;
      exp = {vecs[i].g, vecs[i].b, vecs[i].bs, vecs[i].d};
      act = (vecs[i].sel == 1'b0) ? outs_a() : outs_b();
      check($sformatf("row%0d", i), act, exp);
    end

    // Asynchronous reset while A is blanked in BLANK
    @(negedge clk);
    check("pre_reset_a", outs_a(), {3'd2, 1'b1, 1'b1, 1'b0});
    #2 rst = 1'b1;
    #1;
    check("async_reset_a", outs_a(), 6'b000_0_0_0);
    check("async_reset_b", outs_b(), 6'b000_0_0_0);

    // vblank held high across reset release: the edge lands in IDLE
    @(negedge clk);
    ifa.vblank = 1'b1; ifa.mode_req = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_vbl_high", outs_a(), 6'b000_0_0_0);
    @(negedge clk);
    ifa.mode_req = 3'd1;
    @(posedge clk); #1;
    check("rel_req", outs_a(), 6'b000_0_1_0);
    @(posedge clk); #1;
    check("rel_vbl_held", outs_a(), 6'b000_0_1_0);
    @(negedge clk);
    ifa.vblank = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    ifa.vblank = 1'b1;
    @(posedge clk); #1;
    check("rel_blank", outs_a(), 6'b000_1_1_0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
